evr_event_filter: RTL

- evrClk-domain stage directly upstream of the event logger.
- Turns the raw received character stream (evChar/evCharIsK) into qualified event strobes (evrCode/evrCodeValid) that feed the logger FIFOs.
- Applies a per-code 256-entry pass mask so only selected events reach the logger.
- Decodes the seconds shift protocol (0x70/0x71/0x7D) into a latched 32-bit seconds value with error flagging.

---
 rtl/evr_event_filter_pkg.sv | 22 ++
 rtl/evr_event_filter_if.sv | 45 ++++
 rtl/evr_event_filter_seconds_decoder.sv | 58 +++++
 rtl/evr_event_filter.sv | 98 +++++++++
 4 files changed

// File: rtl/evr_event_filter_pkg.sv
// evr_event_filter_pkg: event codes shared by the filter, the logger and the
// timestamp blocks, plus the "is this character an event" qualifier.
package evr_event_filter_pkg;

  // Null event: never forwarded.
  localparam logic [7:0] EVR_CODE_NULL   = 8'h00;
  // Seconds shift protocol.
  localparam logic [7:0] EVR_CODE_SHIFT0 = 8'h70;
  localparam logic [7:0] EVR_CODE_SHIFT1 = 8'h71;
  localparam logic [7:0] EVR_CODE_LATCH  = 8'h7D;

  // A complete seconds word is exactly this many shifts.
  localparam logic [5:0] SEC_SHIFT_FULL  = 6'd32;
  // The shift counter parks here, so any overrun is still seen at latch time.
  localparam logic [5:0] SEC_SHIFT_SAT   = 6'd33;

  // Data characters other than the null code are events; K characters never are.
  function automatic logic isEvent(input logic [7:0] ch, input logic isK);
    return !isK && (ch != EVR_CODE_NULL);
  endfunction

endpackage

// File: rtl/evr_event_filter_if.sv
// evr_event_filter_if: character input, mask write port and filtered event /
// seconds outputs of the event filter. slave = filter side, master = driver.
// Optional statistics ports exist only when EVR_FILTER_STATS_EN is defined.
interface evr_event_filter_if;

  logic [7:0]  evChar;
  logic        evCharIsK;
  logic        maskWrEnable;
  logic [7:0]  maskWrAddr;
  logic        maskWrData;
  logic [7:0]  evrCode;
  logic        evrCodeValid;
  logic [31:0] evrSeconds;
  logic        evrSecondsValid;
  logic        evrSecondsError;
  logic        evrSecondsGood;
`ifdef EVR_FILTER_STATS_EN
  logic        statsClear;
  logic [31:0] evrPassCount;
  logic [31:0] evrDropCount;

  modport slave (
    input  evChar, evCharIsK, maskWrEnable, maskWrAddr, maskWrData, statsClear,
    output evrCode, evrCodeValid, evrSeconds, evrSecondsValid, evrSecondsError,
           evrSecondsGood, evrPassCount, evrDropCount
  );
  modport master (
    output evChar, evCharIsK, maskWrEnable, maskWrAddr, maskWrData, statsClear,
    input  evrCode, evrCodeValid, evrSeconds, evrSecondsValid, evrSecondsError,
           evrSecondsGood, evrPassCount, evrDropCount
  );
`else
  modport slave (
    input  evChar, evCharIsK, maskWrEnable, maskWrAddr, maskWrData,
    output evrCode, evrCodeValid, evrSeconds, evrSecondsValid, evrSecondsError,
           evrSecondsGood
  );
  modport master (
    output evChar, evCharIsK, maskWrEnable, maskWrAddr, maskWrData,
    input  evrCode, evrCodeValid, evrSeconds, evrSecondsValid, evrSecondsError,
           evrSecondsGood
  );
`endif

endinterface

// File: rtl/evr_event_filter_seconds_decoder.sv
// evr_seconds_decoder: shift/latch protocol for the 32-bit seconds value.
// Fed from the registered input stage; outputs are registered so the strobes
// line up with the latch event's own evrCodeValid cycle.
module evr_seconds_decoder
  import evr_event_filter_pkg::*;
#(
  parameter logic [7:0] CODE_SHIFT0 = EVR_CODE_SHIFT0,
  parameter logic [7:0] CODE_SHIFT1 = EVR_CODE_SHIFT1,
  parameter logic [7:0] CODE_LATCH  = EVR_CODE_LATCH
) (
  input  logic        evrClk,
  input  logic        evrReset,
  input  logic        eventValid,
  input  logic [7:0]  eventCode,
  output logic [31:0] seconds,
  output logic        secondsValid,
  output logic        secondsError,
  output logic        secondsGood
);

  logic [31:0] shiftReg;
  logic [5:0]  shiftCount;

  // Shift in protocol bits, then latch or reject on the latch code.
  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      shiftReg     <= '0;
      shiftCount   <= '0;
      seconds      <= '0;
      secondsValid <= 1'b0;
      secondsError <= 1'b0;
      secondsGood  <= 1'b0;
    end else begin
      secondsValid <= 1'b0;
      secondsError <= 1'b0;
      if (eventValid) begin
        if (eventCode == CODE_SHIFT0 || eventCode == CODE_SHIFT1) begin
          shiftReg <= {shiftReg[30:0], (eventCode == CODE_SHIFT1)};
          if (shiftCount != SEC_SHIFT_SAT) begin
            shiftCount <= shiftCount + 6'd1;
          end
        end else if (eventCode == CODE_LATCH) begin
          // shiftReg is kept; only the count restarts for the next word.
          shiftCount <= '0;
          if (shiftCount == SEC_SHIFT_FULL) begin
            seconds      <= shiftReg;
            secondsValid <= 1'b1;
            secondsGood  <= 1'b1;
          end else begin
            secondsError <= 1'b1;
            secondsGood  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/evr_event_filter.sv
// evr_event_filter: raw character stream -> masked event strobes (latency 2),
// plus the seconds decoder. Define EVR_FILTER_STATS_EN to add pass/drop
// counters and the statsClear input.
module evr_event_filter
  import evr_event_filter_pkg::*;
#(
  parameter logic       MASK_RESET  = 1'b1,
  parameter logic [7:0] CODE_SHIFT0 = EVR_CODE_SHIFT0,
  parameter logic [7:0] CODE_SHIFT1 = EVR_CODE_SHIFT1,
  parameter logic [7:0] CODE_LATCH  = EVR_CODE_LATCH
) (
  input  logic              evrClk,
  input  logic              evrReset,
  evr_event_filter_if.slave evrBus
);

  logic [255:0] maskReg;
  logic [7:0]   s0Code;
  logic         s0Event;
  logic [7:0]   s1Code;
  logic         s1Event;
  logic         s1Pass;

  // One flop per event code; a lookup in the write cycle sees the old bit.
  for (genvar gi = 0; gi < 256; gi++) begin : gMask
    // Mask bit gi: load on a write addressed to code gi.
    always_ff @(posedge evrClk or posedge evrReset) begin
      if (evrReset) begin
        maskReg[gi] <= MASK_RESET;
      end else if (evrBus.maskWrEnable && (evrBus.maskWrAddr == 8'(gi))) begin
        maskReg[gi] <= evrBus.maskWrData;
      end
    end
  end

  // Two-stage filter pipeline: register input, then register its mask bit.
  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      s0Code  <= '0;
      s0Event <= 1'b0;
      s1Code  <= '0;
      s1Event <= 1'b0;
      s1Pass  <= 1'b0;
    end else begin
      s0Code  <= evrBus.evChar;
      s0Event <= isEvent(evrBus.evChar, evrBus.evCharIsK);
      s1Code  <= s0Code;
      s1Event <= s0Event;
      s1Pass  <= maskReg[s0Code];
    end
  end

  assign evrBus.evrCode      = s1Code;
  assign evrBus.evrCodeValid = s1Event & s1Pass;

  // The seconds protocol ignores the mask: it sees every qualified event.
  evr_seconds_decoder #(
    .CODE_SHIFT0 (CODE_SHIFT0),
    .CODE_SHIFT1 (CODE_SHIFT1),
    .CODE_LATCH  (CODE_LATCH)
  ) secondsDecoder (
    .evrClk       (evrClk),
    .evrReset     (evrReset),
    .eventValid   (s0Event),
    .eventCode    (s0Code),
    .seconds      (evrBus.evrSeconds),
    .secondsValid (evrBus.evrSecondsValid),
    .secondsError (evrBus.evrSecondsError),
    .secondsGood  (evrBus.evrSecondsGood)
  );

`ifdef EVR_FILTER_STATS_EN
  logic [31:0] passCount;
  logic [31:0] dropCount;

  // Free-running pass/drop counters; clear wins over a same-cycle increment.
  always_ff @(posedge evrClk or posedge evrReset) begin
    if (evrReset) begin
      passCount <= '0;
      dropCount <= '0;
    end else if (evrBus.statsClear) begin
      passCount <= '0;
      dropCount <= '0;
    end else begin
      if (s1Event && s1Pass) begin
        passCount <= passCount + 32'd1;
      end
      if (s1Event && !s1Pass) begin
        dropCount <= dropCount + 32'd1;
      end
    end
  end

  assign evrBus.evrPassCount = passCount;
  assign evrBus.evrDropCount = dropCount;
`endif

endmodule
